// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, 8-entry register file with bypassed read ports, halt and retirement tracking
module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 16,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MW_valid,
  input  logic [DATA_W-1:0] MW_readMemData,
  input  logic [DATA_W-1:0] MW_aluOut,
  input  logic [DATA_W-1:0] MW_specOps,
  input  logic [DATA_W-1:0] MW_pc_inc,
  input  logic [DATA_W-1:0] MW_next_pc,
  input  logic [1:0]        MW_regSrc,
  input  logic              MW_regWrite,
  input  logic [AW-1:0]     MW_writeReg,
  input  logic              MW_halt,
  input  logic [AW-1:0]     rdReg1,
  input  logic [AW-1:0]     rdReg2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic [DATA_W-1:0] wbData,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output logic [DATA_W-1:0] last_pc
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] last_pc_q, last_pc_d;
  logic              commit, wr_en;

  assign commit = MW_valid & ~halted_q;
  // a HALT retires but never writes its destination
  assign wr_en  = commit & MW_regWrite & ~MW_halt;

  always_comb begin
    wbData = MW_regSrc == 2'b00 ? MW_readMemData :
             MW_regSrc == 2'b01 ? MW_aluOut :
             MW_regSrc == 2'b10 ? MW_specOps : MW_pc_inc;
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = (wr_en && MW_writeReg == AW'(i)) ? wbData : regs_q[i];
    halted_d  = halted_q | (commit & MW_halt);
    retired_d = commit ? retired_q + 1'b1 : retired_q;
    last_pc_d = commit ? MW_next_pc : last_pc_q;
  end

  assign rdData1 = (wr_en && MW_writeReg == rdReg1) ? wbData : regs_q[rdReg1];
  assign rdData2 = (wr_en && MW_writeReg == rdReg2) ? wbData : regs_q[rdReg2];
  assign halted  = halted_q;
  assign retired = retired_q;
  assign last_pc = last_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
      last_pc_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      halted_q  <= halted_d;
      retired_q <= retired_d;
      last_pc_q <= last_pc_d;
    end
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value and commits it to an 8-entry architectural register file.
- Provides two decode-stage read ports with write-through bypass.
- Tracks halt and retirement, exporting sticky halted status, a retired-instruction count and the last retired next-PC for the bench and the top level.

Parameters:
- DATA_W, 16, width of registers and all data paths.
- NUM_REGS, 8, number of architectural registers. Address width is log2(NUM_REGS) = 3.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- MW_valid  input  1  MEM/WB slot holds a real instruction (0 = bubble).
- MW_readMemData  input  DATA_W  data loaded from memory.
- MW_aluOut  input  DATA_W  ALU result.
- MW_specOps  input  DATA_W  special-op result (SLBI/LBI/BTR etc.).
- MW_pc_inc  input  DATA_W  PC+2 (link value).
- MW_next_pc  input  DATA_W  resolved next PC of the retiring instruction.
- MW_regSrc  input  2  writeback source select.
- MW_regWrite  input  1  register write enable.
- MW_writeReg  input  3  destination register.
- MW_halt  input  1  retiring instruction is HALT.
- rdReg1  input  3  read port 1 address.
- rdReg2  input  3  read port 2 address.
- rdData1  output  DATA_W  read port 1 data.
- rdData2  output  DATA_W  read port 2 data.
- wbData  output  DATA_W  selected writeback value (combinational).
- halted  output  1  sticky halt flag.
- retired  output  CNT_W  count of retired instructions.
- last_pc  output  DATA_W  MW_next_pc of the most recently retired instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers to 0; halted=0, retired=0, last_pc=0.
  - Outputs reflect these values immediately, without waiting for a clock edge.
- wbData select on MW_regSrc: 00 = MW_readMemData, 01 = MW_aluOut, 10 = MW_specOps, 11 = MW_pc_inc.
- Commit condition: commit = MW_valid & ~halted.
- Register write:
  - On a rising edge with commit & MW_regWrite & ~MW_halt, reg[MW_writeReg] <= wbData.
  - A HALT's write is always suppressed.
  - Writes with MW_valid=0 are ignored regardless of MW_regWrite.
- Read ports are combinational. rdDataN = wbData when commit & MW_regWrite & ~MW_halt & (MW_writeReg == rdRegN); otherwise rdDataN = reg[rdRegN].
  - Bypass applies independently to both ports. Both ports may hit the same register simultaneously.
  - Register 0 is an ordinary register (no hardwired zero).
- Retire:
  - On a rising edge with commit=1: retired <= retired + 1 (modulo 2^CNT_W, wraps 0xFFFF -> 0x0000) and last_pc <= MW_next_pc.
  - The HALT instruction itself is counted and its next_pc captured.
- Halt:
  - On a rising edge with commit & MW_halt, halted <= 1. halted is visible the cycle after HALT sits in MEM/WB.
  - Once halted=1, all writes, counter increments and last_pc updates stop until reset.
  - Read ports remain functional while halted (no bypass, since commit=0).
- Simultaneous events:
  - A write and a read of the same register in one cycle returns the new value via bypass.
  - The registered array updates at the edge.
- Reset mid-operation: asynchronous reset clears all state mid-cycle. The first edge after rst deasserts commits normally if inputs are valid.
- Latency:
  - Write to array: 1 edge.
  - Read: 0 cycles.
  - halted, retired, last_pc: 1 edge after the retiring cycle.

Test Plan:
- Reset then read all 8 registers -> rdData1/rdData2 = 0x0000; halted=0, retired=0, last_pc=0.
- Sources into R3: MW_valid=1, regWrite=1, writeReg=3, regSrc=01, aluOut=0x1234 -> reg3=0x1234 after edge, retired=1.
  - Repeat for regSrc 00/10/11 with distinct values: 0xBEEF, 0x00A5, 0x0042; each lands in R3.
- Bypass: same-cycle write of 0xCAFE to R5 with rdReg1=rdReg2=5 -> both read 0xCAFE before the edge.
  - Same write with MW_valid=0 -> reads show the old value and reg5 is unchanged.
- Halt: HALT with regWrite=1, writeReg=2, aluOut=0xFFFF, next_pc=0x0040 -> R2 unchanged, halted=1, last_pc=0x0040, retired incremented.
  - Later valid write of 0x7777 to R2 is ignored and retired frozen.
- Counter wrap: preload by driving 65535 valid retires -> retired=0xFFFF; one more retire -> 0x0000.
- Async reset mid-stream: assert rst low between clock edges after several writes -> registers, halted, retired and last_pc read 0 immediately, before any edge.
